ifetch_stage: RTL

IFETCH_STAGE -- requirements
Module: ifetch_stage

---
 rtl/ifetch_pkg.sv | 31 +++
 rtl/ifetch_pc_reg.sv | 44 ++++
 rtl/ifetch_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module  : ifetch_pkg
// Brief   : Shared widths and FSM encoding for the instruction fetch stage.
//           IFETCH_ALIGN_CHECK_EN adds the FAULT state.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2,
    ST_FAULT  = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/ifetch_pc_reg.sv
// ============================================================================
// Module  : ifetch_pc_reg
// Brief   : Program counter with sequential increment and redirect mux.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        redirect_en,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_d, pc_q;

  // Redirect wins over increment; the FSM never asserts both together.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = target;
    end else if (inc_en) begin
      pc_d = pc_q + 32'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/ifetch_stage.sv
// ============================================================================
// Module  : ifetch_stage
// Brief   : Single-outstanding instruction fetch with branch squash and a
//           decode handshake. IFETCH_ALIGN_CHECK_EN enables the sticky fault.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_INC   = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Branch_Valid,
  input  logic [31:0]        Branch_Target,
  output logic               Imem_Req,
  output logic [31:0]        Imem_Addr,
  input  logic               Imem_Ack,
  input  logic [INSTR_W-1:0] Imem_Data,
  output logic [INSTR_W-1:0] Instr,
  output logic [31:0]        Instr_PC,
  output logic               Instr_Valid,
  input  logic               Instr_Ready,
  output logic [CNT_W-1:0]   Fetch_Count,
  output logic               Fault
);

`ifdef IFETCH_ALIGN_CHECK_EN
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;
`endif

  fetch_state_e       state_d, state_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [31:0]        instr_pc_d, instr_pc_q;
  logic               valid_d, valid_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [31:0]        sq_addr_d, sq_addr_q;
  logic [31:0]        pc;
  logic               req_c;
  logic               pc_inc_c;
  logic               pc_redirect_c;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic               fault_d, fault_q;
`endif

  ifetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk         (Clk),
    .rst         (Reset),
    .inc_en      (pc_inc_c),
    .redirect_en (pc_redirect_c),
    .target      (Branch_Target),
    .pc          (pc)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    valid_d       = valid_q;
    cnt_d         = cnt_q;
    sq_addr_d     = sq_addr_q;
    req_c         = 1'b0;
    pc_inc_c      = 1'b0;
    pc_redirect_c = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    fault_d       = fault_q;
`endif
    case (state_q)
      ST_FETCH: begin
`ifdef IFETCH_ALIGN_CHECK_EN
        if (pc[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else
`endif
        begin
          req_c = 1'b1;
          if (Imem_Ack) begin
            if (Branch_Valid) begin
              pc_redirect_c = 1'b1;
            end else begin
              instr_d    = Imem_Data;
              instr_pc_d = pc;
              valid_d    = 1'b1;
              pc_inc_c   = 1'b1;
              state_d    = ST_HOLD;
            end
          end else if (Branch_Valid) begin
            // The stale request keeps its address until memory acks it.
            sq_addr_d     = pc;
            pc_redirect_c = 1'b1;
            state_d       = ST_SQUASH;
          end
        end
      end
      ST_HOLD: begin
        if (Instr_Ready) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (Branch_Valid || Instr_Ready) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
        pc_redirect_c = Branch_Valid;
      end
      ST_SQUASH: begin
        req_c         = 1'b1;
        pc_redirect_c = Branch_Valid;
        if (Imem_Ack) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_FETCH;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      sq_addr_q  <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      sq_addr_q  <= sq_addr_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign Imem_Req    = req_c & ~Reset;
  assign Imem_Addr   = ((state_q == ST_SQUASH) ? sq_addr_q : pc) & ADDR_MASK;
  assign Instr       = instr_q;
  assign Instr_PC    = instr_pc_q;
  assign Instr_Valid = valid_q;
  assign Fetch_Count = cnt_q;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign Fault       = fault_q;
`else
  assign Fault       = 1'b0;
`endif

endmodule

`default_nettype wire
